// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/NOR unit between two requesters.
// Optional grant counters are built when LOGIC_ARB_STATS_EN is defined.
module logic_unit_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data
`ifdef LOGIC_ARB_STATS_EN
   ,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1
`endif
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             owner_q, owner_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] alu_res;
   logic             win1, accept, rsp_hs;

   // Ready is gated by rst_n so nothing is granted while reset is held.
   assign win1       = req1_valid & (~req0_valid | rr_ptr_q);
   assign req0_ready = rst_n & (state_q == StIdle) & req0_valid & ~win1;
   assign req1_ready = rst_n & (state_q == StIdle) & win1;
   assign accept     = req0_ready | req1_ready;

   assign rsp0_valid = (state_q == StResp) & ~owner_q;
   assign rsp1_valid = (state_q == StResp) & owner_q;
   assign rsp0_data  = rsp0_valid ? result_q : '0;
   assign rsp1_data  = rsp1_valid ? result_q : '0;
   assign rsp_hs     = owner_q ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready);

   always_comb begin
      alu_res = '0;
      unique case (op_q)
         2'b00:   alu_res = a_q & b_q;
         2'b01:   alu_res = a_q | b_q;
         2'b10:   alu_res = a_q ^ b_q;
         2'b11:   alu_res = ~(a_q | b_q);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               owner_d = win1;
               op_d    = win1 ? req1_op : req0_op;
               a_d     = win1 ? req1_a : req0_a;
               b_d     = win1 ? req1_b : req0_b;
               state_d = StExec;
            end
         end
         StExec: begin
            result_d = alu_res;
            state_d  = StResp;
         end
         StResp: begin
            if (rsp_hs) begin
               rr_ptr_d = ~owner_q;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= 1'b0;
         owner_q  <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

`ifdef LOGIC_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (req0_ready && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
      if (req1_ready && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: stimulus queues expected responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic [1:0]  req0_op;
   logic [31:0] req0_a, req0_b, rsp0_data;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [1:0]  req1_op;
   logic [31:0] req1_a, req1_b, rsp1_data;
`ifdef LOGIC_ARB_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1;
`endif

   logic_unit_arbiter #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data)
`ifdef LOGIC_ARB_STATS_EN
      ,
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          id;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_cmp(input bit id, input logic [31:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_unexpected: got response on channel %0d data %h, expected none", id, data);
      end else begin
         e = exp_q.pop_front();
         chk("rsp_channel", 32'(id), 32'(e.id));
         chk("rsp_data", data, e.data);
      end
   endtask

   // Monitor: one pop per response handshake, plus idle-channel sanity.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp0_valid && rsp0_ready) pop_cmp(1'b0, rsp0_data);
         if (rsp1_valid && rsp1_ready) pop_cmp(1'b1, rsp1_data);
         if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
         if (!rsp0_valid && rsp0_data !== 32'd0) chk("rsp0_idle_data", rsp0_data, 32'd0);
         if (!rsp1_valid && rsp1_data !== 32'd0) chk("rsp1_idle_data", rsp1_data, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(input bit n);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if ((n ? req1_ready : req0_ready) === 1'b1) return;
      end
      chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (exp_q.size() == 0) begin
            tick();
            return;
         end
         @(negedge clk);
         #1;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   task automatic run_op(input bit n, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      exp_t e;
      e.id = n;
      e.data = exp;
      exp_q.push_back(e);
      if (n) begin
         req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
      end else begin
         req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
      end
      wait_ready(n);
      tick();
      if (n) req1_valid = 1'b0;
      else req0_valid = 1'b0;
      drain();
   endtask

   task automatic push_exp(input bit id, input logic [31:0] data);
      exp_t e;
      e.id = id;
      e.data = data;
      exp_q.push_back(e);
   endtask

   initial begin
      int  last_cyc;
      bit  got;
      rst_n = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'hF0F0_0000; req0_b = 32'h0000_0F0F;
      req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'hFFFF_0000; req1_b = 32'hFF00_FF00;

      // Reset held with both requests pending
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_rsp1_data", rsp1_data, 32'd0);
`ifdef LOGIC_ARB_STATS_EN
      chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
      chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
      push_exp(1'b0, 32'hF0F0_0F0F);
      push_exp(1'b1, 32'hFF00_0000);
      tick();
      rst_n = 1'b1;

      // First grant goes to requester 0; response two edges after accept
      @(negedge clk); #1;
      chk("first_grant_req0", 32'(req0_ready), 32'd1);
      chk("first_grant_req1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      @(negedge clk); #1;
      chk("exec_rsp0_valid", 32'(rsp0_valid), 32'd0);
      @(negedge clk); #1;
      chk("resp_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("resp_rsp0_data", rsp0_data, 32'hF0F0_0F0F);
      chk("resp_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("resp_req1_ready", 32'(req1_ready), 32'd0);
      wait_ready(1'b1);
      tick();
      req1_valid = 1'b0;
      drain();

      // Remaining opcodes, including full-width NOR
      run_op(1'b1, 2'b10, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
      run_op(1'b0, 2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 2'b11, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0000_00FF);

      // Contention: both valid, grants alternate 0,1,0,1 every 3 cycles
      req0_op = 2'b10; req0_a = 32'h1234_5678; req0_b = 32'hFFFF_0000;
      req1_op = 2'b00; req1_a = 32'h1234_5678; req1_b = 32'h0000_FFFF;
      for (int k = 0; k < 4; k++) push_exp(k[0], k[0] ? 32'h0000_5678 : 32'hEDCB_5678);
      req0_valid = 1'b1; req1_valid = 1'b1;
      last_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (req0_ready || req1_ready) got = 1'b1;
         end
         if (!got) chk("contention_timeout", 32'd0, 32'd1);
         else begin
            chk("contention_order", 32'(req1_ready), 32'(k % 2));
            if (k > 0) chk("contention_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
         end
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain();

      // Backpressure on requester 0 while requester 1 waits
      rsp0_ready = 1'b0;
      req0_op = 2'b01; req0_a = 32'hA5A5_A5A5; req0_b = 32'h0F0F_0F0F;
      req1_op = 2'b10; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_FFFF;
      push_exp(1'b0, 32'hAFAF_AFAF);
      push_exp(1'b1, 32'hFFFF_0000);
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_ready(1'b0);
      tick();
      req0_valid = 1'b0;
      @(negedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
         chk("bp_rsp0_data", rsp0_data, 32'hAFAF_AFAF);
         chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      end
      tick();
      rsp0_ready = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("bp_req1_granted", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      drain();

      // Reset during EXEC drops the operation
      req0_op = 2'b00; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1111_1111;
      req0_valid = 1'b1;
      wait_ready(1'b0);
      tick();
      req0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("midrst_rsp0_data", rsp0_data, 32'd0);
      chk("midrst_req0_ready", 32'(req0_ready), 32'd0);
`ifdef LOGIC_ARB_STATS_EN
      chk("midrst_cnt0", 32'(grant_cnt0), 32'd0);
      chk("midrst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
      repeat (2) @(negedge clk);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("postrst_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
      end
      tick();
      run_op(1'b1, 2'b10, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h2152_BEEF);
      run_op(1'b0, 2'b00, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h0E0D_0E0F);
      run_op(1'b0, 2'b01, 32'h0000_0001, 32'h8000_0000, 32'h8000_0001);
      run_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
      run_op(1'b1, 2'b01, 32'h0000_FFFF, 32'h00FF_0000, 32'h00FF_FFFF);
`ifdef LOGIC_ARB_STATS_EN
      @(negedge clk); #1;
      chk("stats_cnt0", 32'(grant_cnt0), 32'd3);
      chk("stats_cnt1", 32'(grant_cnt1), 32'd2);
`endif
      rst_n = 1'b0;
      #1;
`ifdef LOGIC_ARB_STATS_EN
      chk("stats_clr_cnt0", 32'(grant_cnt0), 32'd0);
      chk("stats_clr_cnt1", 32'(grant_cnt1), 32'd0);
`endif
      chk("final_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the execute stage and the branch/compare path.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, with one operation in flight at a time.
- Operands, opcode and result are all registered; the unit has no combinational path from request operands to response data.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 presents an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- rsp0_valid  output  1  result available for requester 0
- rsp0_ready  input  1  requester 0 takes the result
- rsp0_data  output  WIDTH  result for requester 0
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: same as requester 0, for requester 1

Behaviour:
- FSM states and transitions:
  - IDLE: waits for a request. Leaves for EXEC when a request is accepted.
  - EXEC: always moves to RESP after exactly one cycle.
  - RESP: stays until the owner handshakes the response, then returns to IDLE.
- Reset (rst_n low, asynchronous, in any state including mid-operation):
  - state = IDLE, rr_ptr = 0, owner = 0.
  - Operand, opcode and result registers cleared to 0.
  - All reqN_ready = 0, all rspN_valid = 0, all rspN_data = 0.
  - An operation in flight is dropped and no response is issued.
- Grant rule in IDLE:
  - If only one requester is valid, it wins.
  - If both are valid, the requester equal to rr_ptr wins.
  - reqN_ready is combinational: (state == IDLE) and N is the winner. It is never asserted outside IDLE.
- Accept cycle (reqN_valid and reqN_ready):
  - Capture op, a and b; set owner = N; go to EXEC.
- EXEC: result register = f(op, a, b); go to RESP.
- RESP: rsp[owner]_valid = 1 and rsp[owner]_data = result. The other response channel keeps valid = 0 and data = 0.
- Response handshake (rsp[owner]_valid and rsp[owner]_ready):
  - rr_ptr = ~owner; go to IDLE.
  - If rsp_ready stays low, RESP holds indefinitely with valid and data stable.
- Latency and throughput:
  - Accept at edge T; rspN_valid goes high after edge T+2.
  - The earliest next accept is in the cycle after the response handshake, giving a peak of 1 op per 3 cycles.
- Request and response rules:
  - Requesters must hold valid, op, a and b stable until ready.
  - A deasserted valid before grant withdraws the request with no effect.
  - Both valid in back-to-back operations: grants strictly alternate 0, 1, 0, 1.
  - A requester that is not granted sees ready = 0 and waits.
  - rsp_ready asserted while rsp_valid = 0 has no effect.
- Opcode 11 (NOR) result is ~(a | b), at full WIDTH with no sign or width extension.

Optional Feature:
- Macro: LOGIC_ARB_STATS_EN.
- When defined, two extra outputs are added:
  - grant_cnt0  output  16  count of accepts by requester 0.
  - grant_cnt1  output  16  count of accepts by requester 1.
- Counter rules:
  - Each counter increments on its requester's accept cycle.
  - Each saturates at 16'hFFFF.
  - Both are cleared by rst_n.
- When not defined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with both reqN_valid = 1 -> req0_ready = req1_ready = 0, rsp0_valid = rsp1_valid = 0, rsp data = 0. Release reset -> the first grant goes to requester 0.
- Single op: req0 OR with a = 32'hF0F0_0000, b = 32'h0000_0F0F, accepted at T -> rsp0_valid high after edge T+2, rsp0_data = 32'hF0F0_0F0F, rsp1_valid = 0.
- All opcodes: req1 with a = 32'hFFFF_0000, b = 32'hFF00_FF00:
  - AND -> 32'hFF00_0000
  - XOR -> 32'h00FF_FF00
  - NOR -> 32'h0000_00FF
- Contention: both valid continuously, rspN_ready = 1 -> accept order 0, 1, 0, 1, with one accept every 3 cycles.
- Backpressure: rsp0_ready = 0 for 10 cycles during RESP -> rsp0_valid and rsp0_data stay stable, req1_ready = 0 throughout. Raise rsp0_ready -> requester 1 is granted in the following cycle.
- Mid-op reset: assert rst_n low during EXEC -> outputs clear immediately with no response. After release, a new req1 op completes normally. With LOGIC_ARB_STATS_EN defined, 3 req0 accepts plus 2 req1 accepts -> grant_cnt0 = 3, grant_cnt1 = 2; reset clears both to 0.
